// File: rtl/operand_pairer_pkg.sv
// Shared helpers for the operand pairer: level-counter width and integer MAX/MIN.
package operand_pairer_pkg;

    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/operand_pairer_sync_fifo.sv
// Single-clock FIFO with occupancy level; DEPTH is a power of two so pointers wrap naturally.
module sync_fifo
    import operand_pairer_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int DEPTH = 4
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [NBITS-1:0]             wdata,
    input  logic                         pop,
    output logic [NBITS-1:0]             rdata,
    output logic [lvl_width(DEPTH)-1:0]  level,
    output logic                         full,
    output logic                         empty
);

    localparam int LW = lvl_width(DEPTH);
    localparam int PW = max_int(1, $clog2(DEPTH));

    logic [NBITS-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/operand_pairer.sv
// Buffers two operand streams and emits them pairwise, in order, through a registered output stage.
module operand_pairer
    import operand_pairer_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int DEPTH = 4
)
(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         FLUSH,
    input  logic [NBITS-1:0]             A_DATA,
    input  logic                         A_VALID,
    output logic                         A_READY,
    input  logic [NBITS-1:0]             B_DATA,
    input  logic                         B_VALID,
    output logic                         B_READY,
    output logic [NBITS-1:0]             OUT_A,
    output logic [NBITS-1:0]             OUT_B,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [lvl_width(DEPTH)-1:0]  A_LEVEL,
    output logic [lvl_width(DEPTH)-1:0]  B_LEVEL
);

    logic             a_full;
    logic             a_empty;
    logic             b_full;
    logic             b_empty;
    logic [NBITS-1:0] a_head;
    logic [NBITS-1:0] b_head;
    logic             fire;

    assign A_READY = !a_full;
    assign B_READY = !b_full;

    // Output slot is free when empty or being drained on this same edge.
    assign fire = !a_empty && !b_empty && (!OUT_VALID || OUT_READY);

    sync_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (CLK),
        .rst   (RST),
        .flush (FLUSH),
        .push  (A_VALID),
        .wdata (A_DATA),
        .pop   (fire),
        .rdata (a_head),
        .level (A_LEVEL),
        .full  (a_full),
        .empty (a_empty)
    );

    sync_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (CLK),
        .rst   (RST),
        .flush (FLUSH),
        .push  (B_VALID),
        .wdata (B_DATA),
        .pop   (fire),
        .rdata (b_head),
        .level (B_LEVEL),
        .full  (b_full),
        .empty (b_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_A     <= '0;
            OUT_B     <= '0;
            OUT_VALID <= 1'b0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (fire) begin
            OUT_A     <= a_head;
            OUT_B     <= b_head;
            OUT_VALID <= 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_pairer.sv
// Randomised and directed scoreboard bench for operand_pairer against a queue-based reference model.
module tb_operand_pairer;

    localparam int NBITS = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             CLK;
    logic             RST;
    logic             FLUSH;
    logic [NBITS-1:0] A_DATA;
    logic             A_VALID;
    logic             A_READY;
    logic [NBITS-1:0] B_DATA;
    logic             B_VALID;
    logic             B_READY;
    logic [NBITS-1:0] OUT_A;
    logic [NBITS-1:0] OUT_B;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [LW-1:0]    A_LEVEL;
    logic [LW-1:0]    B_LEVEL;

    operand_pairer #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .A_DATA    (A_DATA),
        .A_VALID   (A_VALID),
        .A_READY   (A_READY),
        .B_DATA    (B_DATA),
        .B_VALID   (B_VALID),
        .B_READY   (B_READY),
        .OUT_A     (OUT_A),
        .OUT_B     (OUT_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .A_LEVEL   (A_LEVEL),
        .B_LEVEL   (B_LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: operand queues plus an expected-pair queue.
    logic [NBITS-1:0]   fa[$];
    logic [NBITS-1:0]   fb[$];
    logic [2*NBITS-1:0] exp_q[$];
    bit                 m_valid = 0;
    bit                 m_zero  = 0;
    bit                 mon_en  = 0;
    int                 na, nb;
    bit                 m_fire;

    // Monitor statistics used by the directed phases.
    int hs = 0;
    int last_a = -1, last_b = -1;
    int run = 0, maxrun = 0;
    int maxa = 0, maxb = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            fa.delete(); fb.delete(); exp_q.delete();
            m_valid = 0;
            m_zero  = 1;
            mon_en  = 1;
        end else if (FLUSH) begin
            fa.delete(); fb.delete(); exp_q.delete();
            m_valid = 0;
        end else begin
            na = fa.size();
            nb = fb.size();
            m_fire = (na > 0) && (nb > 0) && (!m_valid || OUT_READY);
            if (m_fire) begin
                exp_q.push_back({fa.pop_front(), fb.pop_front()});
                m_valid = 1;
                m_zero  = 0;
            end else if (OUT_READY) begin
                m_valid = 0;
            end
            if (A_VALID && na < DEPTH) fa.push_back(A_DATA);
            if (B_VALID && nb < DEPTH) fb.push_back(B_DATA);
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("out_valid", int'(OUT_VALID), int'(m_valid));
            chk("a_level", int'(A_LEVEL), fa.size());
            chk("b_level", int'(B_LEVEL), fb.size());
            chk("a_ready", int'(A_READY), int'(fa.size() < DEPTH));
            chk("b_ready", int'(B_READY), int'(fb.size() < DEPTH));
            if (m_zero) begin
                chk("out_a_reset", int'(OUT_A), 0);
                chk("out_b_reset", int'(OUT_B), 0);
            end
            if (OUT_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", 1, 0);
                end else begin
                    chk("out_a", int'(OUT_A), int'(exp_q[0][2*NBITS-1:NBITS]));
                    chk("out_b", int'(OUT_B), int'(exp_q[0][NBITS-1:0]));
                    if (OUT_READY) begin
                        void'(exp_q.pop_front());
                        hs++;
                        last_a = int'(OUT_A);
                        last_b = int'(OUT_B);
                    end
                end
                run++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
            if (int'(A_LEVEL) > maxa) maxa = int'(A_LEVEL);
            if (int'(B_LEVEL) > maxb) maxb = int'(B_LEVEL);
        end
    end

    task automatic drv(input bit av, input int ad, input bit bv, input int bd,
                       input bit ordy, input bit fl = 0, input bit rs = 0);
        A_VALID   = av;
        A_DATA    = ad[NBITS-1:0];
        B_VALID   = bv;
        B_DATA    = bd[NBITS-1:0];
        OUT_READY = ordy;
        FLUSH     = fl;
        RST       = rs;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, ordy);
    endtask

    int h0;

    initial begin
        A_VALID = 0; A_DATA = '0; B_VALID = 0; B_DATA = '0;
        OUT_READY = 0; FLUSH = 0; RST = 1;
        drv(0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 1);
        chk("ready_a_after_reset", int'(A_READY), 1);
        chk("ready_b_after_reset", int'(B_READY), 1);

        // Basic pairing and latency.
        h0 = hs;
        drv(1, 'h10, 1, 'h20, 1);
        chk("basic_no_bypass", int'(OUT_VALID), 0);
        drv(0, 0, 0, 0, 1);
        chk("basic_valid", int'(OUT_VALID), 1);
        chk("basic_a", int'(OUT_A), 'h10);
        chk("basic_b", int'(OUT_B), 'h20);
        drv(0, 0, 0, 0, 1);
        chk("basic_one_cycle", int'(OUT_VALID), 0);
        chk("basic_hs", hs - h0, 1);

        // Skew.
        h0 = hs; maxa = 0;
        drv(1, 1, 0, 0, 1); drv(1, 2, 0, 0, 1); drv(1, 3, 0, 0, 1);
        drv(0, 0, 1, 9, 1); drv(0, 0, 1, 8, 1); drv(0, 0, 1, 7, 1);
        idle(3, 1);
        chk("skew_peak_a", maxa, 3);
        chk("skew_hs", hs - h0, 3);
        chk("skew_last", last_a * 256 + last_b, 3 * 256 + 7);

        // Full / backpressure.
        for (int i = 0; i < 8; i++) drv(1, $urandom, 1, $urandom, 0);
        chk("full_a_level", int'(A_LEVEL), DEPTH);
        chk("full_b_level", int'(B_LEVEL), DEPTH);
        chk("full_a_ready", int'(A_READY), 0);
        chk("full_b_ready", int'(B_READY), 0);
        chk("full_held", int'(OUT_VALID), 1);
        h0 = hs;
        idle(8, 1);
        chk("full_drain_hs", hs - h0, DEPTH + 1);

        // Throughput.
        maxrun = 0; maxa = 0; maxb = 0;
        for (int i = 0; i < 16; i++) drv(1, $urandom, 1, $urandom, 1);
        idle(3, 1);
        chk("thru_run", maxrun, 16);
        chk("thru_max_a", maxa, 1);
        chk("thru_max_b", maxb, 1);

        // Flush.
        drv(1, 'h41, 1, 'h51, 0);
        drv(1, 'h42, 0, 0, 0);
        drv(1, 'h43, 0, 0, 0);
        chk("pre_flush_valid", int'(OUT_VALID), 1);
        chk("pre_flush_a", int'(A_LEVEL), 2);
        chk("pre_flush_b", int'(B_LEVEL), 0);
        drv(1, 'h44, 0, 0, 0, 1);
        chk("flush_a_level", int'(A_LEVEL), 0);
        chk("flush_b_level", int'(B_LEVEL), 0);
        chk("flush_valid", int'(OUT_VALID), 0);
        h0 = hs;
        drv(0, 0, 1, 5, 1);
        idle(3, 1);
        chk("flush_no_stale", hs - h0, 0);
        drv(1, 6, 0, 0, 1);
        idle(2, 1);
        chk("flush_next_hs", hs - h0, 1);
        chk("flush_next_pair", last_a * 256 + last_b, 6 * 256 + 5);

        // Reset mid-stream.
        drv(1, 'h71, 1, 'h72, 0);
        idle(2, 0);
        chk("pre_reset_valid", int'(OUT_VALID), 1);
        drv(1, 'h73, 1, 'h74, 0, 0, 1);
        chk("reset_valid", int'(OUT_VALID), 0);
        chk("reset_out_a", int'(OUT_A), 0);
        chk("reset_out_b", int'(OUT_B), 0);
        chk("reset_a_level", int'(A_LEVEL), 0);
        chk("reset_b_level", int'(B_LEVEL), 0);
        chk("reset_a_ready", int'(A_READY), 1);
        chk("reset_b_ready", int'(B_READY), 1);
        h0 = hs;
        drv(1, 'h33, 1, 'h44, 1);
        idle(2, 1);
        chk("reset_next_hs", hs - h0, 1);
        chk("reset_next_pair", last_a * 256 + last_b, 'h33 * 256 + 'h44);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom % 2), $urandom, 1'($urandom % 2), $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) drv(0, 0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
